stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter SP_RESET, default 32'h0000_0FFF, meaning stack pointer value after reset.
REQ-002 SHALL have parameter INT_VECTOR, default 32'h0000_0000, meaning PC loaded on interrupt entry.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 op_valid  input  1  one-cycle pulse from decode: stack op present.
REQ-006 op_call / op_ret / op_rti  input  1 each  op select, qualified by op_valid.
REQ-007 int_req  input  1  interrupt request level.
REQ-008 pc_in  input  32  return PC to save, i.e. the next-instruction PC.
REQ-009 target_in  input  32  CALL destination.
REQ-010 flags_in  input  3  CCR {C,N,Z} to save on interrupt.
REQ-011 mem_ready  input  1  memory accepts or returns the current access this cycle.
REQ-012 mem_rdata  input  16  read data, valid when mem_ready=1 and mem_we=0.
REQ-013 busy  output  1  high whenever state != IDLE; stalls fetch/decode.
REQ-014 mem_req / mem_we  output  1 each  access request / write enable.
REQ-015 mem_addr  output  32  access address; mem_wdata output 16, write data.
REQ-016 pc_load  output  1  one-cycle pulse, pc_out valid.
REQ-017 pc_out  output  32  new PC; flags_load output 1 pulse, flags_out output 3.
REQ-018 sp_out  output  32  current stack pointer; done output 1, one-cycle pulse at sequence end.

Function
REQ-019 States SHALL be IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, LOAD.
REQ-020 In IDLE, int_req=1 SHALL start INT (PUSH_HI->PUSH_LO->PUSH_FLG->LOAD, pc_out=INT_VECTOR); int_req wins over a simultaneous op_valid, and that op is dropped.
REQ-021 In IDLE with op_valid=1, priority SHALL be CALL (PUSH_HI->PUSH_LO->LOAD, pc_out=target_in) > RET (POP_LO->POP_HI->LOAD) > RTI (POP_FLG->POP_LO->POP_HI->LOAD).
REQ-022 pc_in, target_in and flags_in SHALL be captured on the accept edge; later changes are ignored.
REQ-023 op_valid and int_req SHALL be ignored while busy=1.
REQ-024 Push states: mem_req=1, mem_we=1, mem_addr=SP, mem_wdata = pc[31:16] / pc[15:0] / {13'b0,flags}; on mem_ready, SP<=SP-1 and advance.
REQ-025 Pop states: mem_req=1, mem_we=0, mem_addr=SP+1; on mem_ready, SP<=SP+1, capture mem_rdata into flags[2:0] / pc[15:0] / pc[31:16], and advance.
REQ-026 A memory state without mem_ready SHALL hold state, address, data and SP unchanged (unbounded wait).
REQ-027 LOAD SHALL last one cycle with pc_load=1 and done=1, plus flags_load=1 for RTI only; the next state is IDLE.
REQ-028 mem_req, pc_load, flags_load and done SHALL be 0 in all other states.
REQ-029 SP arithmetic SHALL be 32-bit modulo 2^32 (0-1 -> FFFF_FFFF, FFFF_FFFF+1 -> 0), with no error flag.
REQ-030 An op with op_valid=1 and no select bit set SHALL be ignored; the block stays IDLE.
REQ-031 Latency with mem_ready tied high: CALL/RET busy 3 cycles, INT/RTI busy 4 cycles, counted from the cycle after accept.

Reset
REQ-032 rst=1 SHALL force state=IDLE, SP=SP_RESET, pc_out=0, flags_out=0 and all pulse/request outputs to 0 on the next edge, including mid-sequence; partial pushes or pops are abandoned.
REQ-033 The first op SHALL be accepted in the first cycle with rst=0.

Verification
REQ-034 CALL, pc_in=0x0001_2345, target_in=0x0000_0100, mem_ready=1 -> writes 0x0001 at 0x0FFF, then 0x2345 at 0x0FFE, then pc_load with pc_out=0x100, sp_out=0x0FFD.
REQ-035 RET right after REQ-034 -> reads addr 0x0FFE (0x2345), then 0x0FFF (0x0001), then pc_out=0x0001_2345, sp_out=0x0FFF.
REQ-036 int_req and op_valid/op_call in the same IDLE cycle, flags_in=3'b101 -> INT sequence, third write 0x0005 at 0x0FFD, pc_out=INT_VECTOR, CALL dropped; then RTI -> flags_out=3'b101 with flags_load pulse, pc restored.
REQ-037 mem_ready low for 5 cycles during PUSH_LO -> mem_addr and mem_wdata stable, SP unchanged, busy held, and the sequence completes correctly.
REQ-038 rst asserted in POP_HI -> next cycle IDLE, busy=0, sp_out=0x0FFF, no pc_load pulse.
REQ-039 SP_RESET=0 with a single RET -> reads at addr 0x1 then 0x2, sp_out=0x2; a CALL from SP=0 writes at 0x0 then 0xFFFF_FFFF.

Source files
------------

// File: rtl/stack_sequencer.sv
// Call/return/interrupt stack sequencer: pushes and pops a 32-bit PC (and CCR flags on
// interrupt) through a 16-bit memory port, then hands the new PC back to fetch.
module stack_sequencer #(
  parameter logic [31:0] SP_RESET   = 32'h0000_0FFF,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_call,
  input  logic        op_ret,
  input  logic        op_rti,
  input  logic        int_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] target_in,
  input  logic [2:0]  flags_in,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic [31:0] sp_out,
  output logic        done
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 3;

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, LOAD
  } state_t;

  typedef enum logic [1:0] {K_CALL, K_RET, K_RTI, K_INT} kind_t;

  state_t        state, state_n;
  kind_t         kind, kind_n;
  logic [AW-1:0] sp, sp_n;
  logic [AW-1:0] pc_r, pc_n;
  logic [AW-1:0] tgt_r, tgt_n;
  logic [FW-1:0] flg_r, flg_n;

  logic          mem_req_n, mem_we_n, pc_load_n, flags_load_n;
  logic [AW-1:0] mem_addr_n, pc_out_n;
  logic [DW-1:0] mem_wdata_n;
  logic [FW-1:0] flags_out_n;

  // Next-state, stack pointer and captured-context update.
  always_comb begin
    state_n = state;
    kind_n  = kind;
    sp_n    = sp;
    pc_n    = pc_r;
    tgt_n   = tgt_r;
    flg_n   = flg_r;
    unique case (state)
      IDLE: begin
        if (int_req) begin
          kind_n  = K_INT;
          pc_n    = pc_in;
          flg_n   = flags_in;
          state_n = PUSH_HI;
        end else if (op_valid) begin
          if (op_call) begin
            kind_n  = K_CALL;
            pc_n    = pc_in;
            tgt_n   = target_in;
            state_n = PUSH_HI;
          end else if (op_ret) begin
            kind_n  = K_RET;
            state_n = POP_LO;
          end else if (op_rti) begin
            kind_n  = K_RTI;
            state_n = POP_FLG;
          end
        end
      end
      PUSH_HI: begin
        if (mem_ready) begin
          sp_n    = sp - AW'(1);
          state_n = PUSH_LO;
        end
      end
      PUSH_LO: begin
        if (mem_ready) begin
          sp_n    = sp - AW'(1);
          state_n = (kind == K_INT) ? PUSH_FLG : LOAD;
        end
      end
      PUSH_FLG: begin
        if (mem_ready) begin
          sp_n    = sp - AW'(1);
          state_n = LOAD;
        end
      end
      POP_FLG: begin
        if (mem_ready) begin
          sp_n    = sp + AW'(1);
          flg_n   = mem_rdata[FW-1:0];
          state_n = POP_LO;
        end
      end
      POP_LO: begin
        if (mem_ready) begin
          sp_n       = sp + AW'(1);
          pc_n[15:0] = mem_rdata;
          state_n    = POP_HI;
        end
      end
      POP_HI: begin
        if (mem_ready) begin
          sp_n        = sp + AW'(1);
          pc_n[31:16] = mem_rdata;
          state_n     = LOAD;
        end
      end
      LOAD: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so every output is a flop.
  always_comb begin
    mem_req_n    = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = '0;
    mem_wdata_n  = '0;
    pc_load_n    = 1'b0;
    flags_load_n = 1'b0;
    pc_out_n     = pc_out;
    flags_out_n  = flags_out;
    unique case (state_n)
      PUSH_HI: begin
        mem_req_n   = 1'b1;
        mem_we_n    = 1'b1;
        mem_addr_n  = sp_n;
        mem_wdata_n = pc_n[31:16];
      end
      PUSH_LO: begin
        mem_req_n   = 1'b1;
        mem_we_n    = 1'b1;
        mem_addr_n  = sp_n;
        mem_wdata_n = pc_n[15:0];
      end
      PUSH_FLG: begin
        mem_req_n   = 1'b1;
        mem_we_n    = 1'b1;
        mem_addr_n  = sp_n;
        mem_wdata_n = {13'b0, flg_n};
      end
      POP_FLG, POP_LO, POP_HI: begin
        mem_req_n  = 1'b1;
        mem_addr_n = sp_n + AW'(1);
      end
      LOAD: begin
        pc_load_n = 1'b1;
        unique case (kind_n)
          K_CALL:  pc_out_n = tgt_n;
          K_INT:   pc_out_n = INT_VECTOR;
          default: pc_out_n = pc_n;
        endcase
        if (kind_n == K_RTI) begin
          flags_load_n = 1'b1;
          flags_out_n  = flg_n;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind       <= K_CALL;
      sp         <= SP_RESET;
      pc_r       <= '0;
      tgt_r      <= '0;
      flg_r      <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pc_load    <= 1'b0;
      pc_out     <= '0;
      flags_load <= 1'b0;
      flags_out  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      kind       <= kind_n;
      sp         <= sp_n;
      pc_r       <= pc_n;
      tgt_r      <= tgt_n;
      flg_r      <= flg_n;
      busy       <= (state_n != IDLE);
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      pc_load    <= pc_load_n;
      pc_out     <= pc_out_n;
      flags_load <= flags_load_n;
      flags_out  <= flags_out_n;
      done       <= pc_load_n;
    end
  end

  assign sp_out = sp;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: CALL/RET, INT/RTI, memory stall, mid-sequence
// reset and stack-pointer wraparound, against hand-computed values.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_call, op_ret, op_rti, int_req;
  logic [31:0] pc_in, target_in;
  logic [2:0]  flags_in;
  logic        mem_ready;
  logic [15:0] mem_rdata;

  logic        busy, mem_req, mem_we, pc_load, flags_load, done;
  logic [31:0] mem_addr, pc_out, sp_out;
  logic [15:0] mem_wdata;
  logic [2:0]  flags_out;

  logic        z_busy, z_mem_req, z_mem_we, z_pc_load, z_flags_load, z_done;
  logic [31:0] z_mem_addr, z_pc_out, z_sp_out;
  logic [15:0] z_mem_wdata;
  logic [2:0]  z_flags_out;

  logic [15:0] mem [16];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stack_sequencer #(.SP_RESET(32'h0000_0FFF), .INT_VECTOR(32'h0000_0200)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_call(op_call), .op_ret(op_ret),
    .op_rti(op_rti), .int_req(int_req), .pc_in(pc_in), .target_in(target_in),
    .flags_in(flags_in), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_load(pc_load), .pc_out(pc_out), .flags_load(flags_load), .flags_out(flags_out),
    .sp_out(sp_out), .done(done)
  );

  stack_sequencer #(.SP_RESET(32'h0000_0000)) dut_zero (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_call(op_call), .op_ret(op_ret),
    .op_rti(op_rti), .int_req(int_req), .pc_in(pc_in), .target_in(target_in),
    .flags_in(flags_in), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(z_busy),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .pc_load(z_pc_load), .pc_out(z_pc_out), .flags_load(z_flags_load),
    .flags_out(z_flags_out), .sp_out(z_sp_out), .done(z_done)
  );

  // Small stack memory seen by the main instance (addresses 0xFF0..0xFFF fold onto 16 words).
  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) mem[mem_addr[3:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 0; op_call = 0; op_ret = 0; op_rti = 0; int_req = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    pc_in = '0; target_in = '0; flags_in = '0; mem_ready = 1;
    step(); step();
    rst = 0;
    check("rst_busy", 32'(busy), 0);
    check("rst_sp", sp_out, 32'h0FFF);
    check("rst_pc_out", pc_out, 0);
    check("rst_req_done", {29'b0, mem_req, pc_load, done}, 0);

    // CALL accepted in the first cycle out of reset
    op_valid = 1; op_call = 1; pc_in = 32'h0001_2345; target_in = 32'h0000_0100;
    step();
    op_call = 0; op_ret = 1; pc_in = 32'hDEAD_BEEF; target_in = 32'h0BAD_0000;
    check("call_hi_ctl", {29'b0, busy, mem_req, mem_we}, 3'b111);
    check("call_hi_addr", mem_addr, 32'h0FFF);
    check("call_hi_data", 32'(mem_wdata), 32'h0001);
    step();
    check("call_lo_addr", mem_addr, 32'h0FFE);
    check("call_lo_data", 32'(mem_wdata), 32'h2345);
    step();
    idle_inputs();
    check("call_load", {29'b0, pc_load, done, flags_load}, 3'b110);
    check("call_pc_out", pc_out, 32'h0000_0100);
    check("call_sp", sp_out, 32'h0FFD);
    check("call_load_req", 32'(mem_req), 0);
    step();
    check("call_idle", {30'b0, busy, pc_load}, 0);
    check("call_pc_hold", pc_out, 32'h0000_0100);

    // RET
    op_valid = 1; op_ret = 1;
    step();
    idle_inputs();
    check("ret_lo_ctl", {30'b0, mem_req, mem_we}, 2'b10);
    check("ret_lo_addr", mem_addr, 32'h0FFE);
    step();
    check("ret_hi_addr", mem_addr, 32'h0FFF);
    step();
    check("ret_pc_out", pc_out, 32'h0001_2345);
    check("ret_sp", sp_out, 32'h0FFF);
    check("ret_flags_load", 32'(flags_load), 0);
    step();

    // INT wins over simultaneous CALL
    int_req = 1; op_valid = 1; op_call = 1; flags_in = 3'b101;
    pc_in = 32'h0000_ABCD; target_in = 32'h0000_0777;
    step();
    idle_inputs(); flags_in = 3'b010;
    check("int_hi_addr", mem_addr, 32'h0FFF);
    check("int_hi_data", 32'(mem_wdata), 32'h0000);
    step();
    check("int_lo_data", 32'(mem_wdata), 32'hABCD);
    step();
    check("int_flg_addr", mem_addr, 32'h0FFD);
    check("int_flg_data", 32'(mem_wdata), 32'h0005);
    step();
    check("int_pc_out", pc_out, 32'h0000_0200);
    check("int_sp", sp_out, 32'h0FFC);
    check("int_flags_load", 32'(flags_load), 0);
    step();

    // RTI restores flags and PC
    op_valid = 1; op_rti = 1;
    step();
    idle_inputs();
    check("rti_flg_addr", mem_addr, 32'h0FFD);
    step(); step();
    check("rti_hi_addr", mem_addr, 32'h0FFF);
    step();
    check("rti_load", {29'b0, pc_load, flags_load, done}, 3'b111);
    check("rti_flags_out", 32'(flags_out), 32'h5);
    check("rti_pc_out", pc_out, 32'h0000_ABCD);
    check("rti_sp", sp_out, 32'h0FFF);
    step();

    // op_valid with no select is ignored
    op_valid = 1;
    step();
    idle_inputs();
    check("nosel_busy", 32'(busy), 0);

    // CALL with a 5-cycle memory stall in PUSH_LO
    op_valid = 1; op_call = 1; pc_in = 32'h1234_5678; target_in = 32'h0000_0300;
    step();
    idle_inputs();
    step();
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_addr", mem_addr, 32'h0FFE);
      check("stall_data", 32'(mem_wdata), 32'h5678);
      check("stall_sp_busy", {sp_out[30:0], busy}, {31'h0FFE, 1'b1});
    end
    mem_ready = 1;
    step();
    check("stall_pc_out", pc_out, 32'h0000_0300);
    check("stall_sp", sp_out, 32'h0FFD);
    step();
    check("stall_mem_lo", 32'(mem[4'hE]), 32'h5678);

    // Reset during POP_HI of a RET
    op_valid = 1; op_ret = 1;
    step();
    idle_inputs();
    step();
    check("pre_rst_addr", mem_addr, 32'h0FFF);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_sp", sp_out, 32'h0FFF);
    check("mid_rst_pulses", {29'b0, pc_load, mem_req, done}, 0);
    step();
    check("mid_rst_no_load", {30'b0, pc_load, busy}, 0);

    // Stack pointer wraparound on the SP_RESET=0 instance
    op_valid = 1; op_ret = 1;
    step();
    idle_inputs();
    check("z_ret_addr1", z_mem_addr, 32'h1);
    step();
    check("z_ret_addr2", z_mem_addr, 32'h2);
    step();
    check("z_ret_sp", z_sp_out, 32'h2);
    rst = 1;
    step();
    rst = 0;
    op_valid = 1; op_call = 1; pc_in = 32'h0000_0040; target_in = 32'h0000_0080;
    step();
    idle_inputs();
    check("z_call_addr0", z_mem_addr, 32'h0);
    step();
    check("z_call_addr1", z_mem_addr, 32'hFFFF_FFFF);
    step();
    check("z_call_sp", z_sp_out, 32'hFFFF_FFFE);
    check("z_call_pc_out", z_pc_out, 32'h0000_0080);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
